inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue_if.sv | 29 ++
 rtl/inst_fetch_queue.sv | 90 +++++++++
 tb/tb_inst_fetch_queue.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Bus between the fetch queue, the i-cache, the decoder and the ROB redirect path.
// The master modport is the fetch-queue view; slave is the view of the surrounding blocks.
interface inst_fetch_queue_if;
    logic        if_icache_en_out;
    logic [31:0] if_icache_inst_addr_out;
    logic        icache_if_rdy_in;
    logic        icache_if_miss_in;
    logic [31:0] icache_if_inst_inst_in;
    logic        if_dec_valid_out;
    logic [31:0] if_dec_inst_out;
    logic [31:0] if_dec_pc_out;
    logic        dec_if_ready_in;
    logic        rob_if_flush_in;
    logic [31:0] rob_if_target_in;

    modport master (
        output if_icache_en_out, if_icache_inst_addr_out,
               if_dec_valid_out, if_dec_inst_out, if_dec_pc_out,
        input  icache_if_rdy_in, icache_if_miss_in, icache_if_inst_inst_in,
               dec_if_ready_in, rob_if_flush_in, rob_if_target_in
    );

    modport slave (
        input  if_icache_en_out, if_icache_inst_addr_out,
               if_dec_valid_out, if_dec_inst_out, if_dec_pc_out,
        output icache_if_rdy_in, icache_if_miss_in, icache_if_inst_inst_in,
               dec_if_ready_in, rob_if_flush_in, rob_if_target_in
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the PC, follows JAL statically and buffers
// {pc, inst} pairs in a circular queue for the decoder; ROB flush redirects.
module inst_fetch_queue #(
    parameter int          QueueDepthLog = 4,
    parameter logic [31:0] ResetPc       = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    inst_fetch_queue_if.master    bus
);
    localparam int                   Depth  = 1 << QueueDepthLog;
    localparam logic [QueueDepthLog:0] DepthC = (QueueDepthLog+1)'(Depth);

    typedef enum logic {FETCH, WAIT} state_t;

    state_t                   r_state;
    logic [31:0]              r_pc;
    logic [QueueDepthLog-1:0] r_head, r_tail;
    logic [QueueDepthLog:0]   r_count;
    logic [31:0]              r_q_pc   [Depth];
    logic [31:0]              r_q_inst [Depth];

    logic        w_full, w_empty, w_flush, w_en, w_hit, w_pop, w_dec_valid;
    logic [31:0] w_inst, w_imm, w_next_pc;

    assign w_full  = (r_count == DepthC);
    assign w_empty = (r_count == '0);
    assign w_flush = bus.rob_if_flush_in;
    assign w_inst  = bus.icache_if_inst_inst_in;

    // WAIT keeps the miss request alive regardless of the cache's rdy; full is
    // impossible there because it was checked before the original issue.
    assign w_en = rdy_in && !rst_in && !w_flush &&
                  ((r_state == WAIT) || (!w_full && bus.icache_if_rdy_in));
    assign w_hit       = w_en && !bus.icache_if_miss_in;
    assign w_dec_valid = !rst_in && !w_flush && !w_empty;
    assign w_pop       = w_dec_valid && bus.dec_if_ready_in && rdy_in;

    assign w_imm     = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                        w_inst[30:21], 1'b0};
    assign w_next_pc = (w_inst[6:0] == 7'b1101111) ? r_pc + w_imm : r_pc + 32'd4;

    assign bus.if_icache_en_out        = w_en;
    assign bus.if_icache_inst_addr_out = r_pc;
    assign bus.if_dec_valid_out        = w_dec_valid;
    assign bus.if_dec_inst_out         = w_empty ? 32'h0 : r_q_inst[r_head];
    assign bus.if_dec_pc_out           = w_empty ? 32'h0 : r_q_pc[r_head];

    // Storage needs no reset: the outputs are masked to zero while empty.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && w_hit) begin
            r_q_pc[r_tail]   <= r_pc;
            r_q_inst[r_tail] <= w_inst;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= FETCH;
            r_pc    <= ResetPc;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (w_flush) begin
                r_state <= FETCH;
                r_pc    <= bus.rob_if_target_in;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_hit) begin
                    r_pc    <= w_next_pc;
                    r_tail  <= r_tail + 1'b1;
                    r_state <= FETCH;
                end else if (w_en) begin
                    r_state <= WAIT;
                end
                if (w_pop)
                    r_head <= r_head + 1'b1;
                case ({w_hit, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a queue-based behavioural model of the fetch front end.
module tb_inst_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(.QueueDepthLog(4), .ResetPc(32'h0)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [31:0] m_pc = 32'h0;
    bit          m_wait = 1'b0;
    logic [31:0] mq_pc   [$];
    logic [31:0] mq_inst [$];

    // outputs sampled in the most recent cycle
    logic        s_en, s_dv;
    logic [31:0] s_addr, s_inst, s_pc;

    localparam logic [31:0] NOP = 32'h00000013;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst);
        int signed off;
        if (inst[6:0] == 7'b1101111) begin
            off = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            off = (off << 11) >>> 11;
            return pc + off;
        end
        return pc + 32'd4;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input bit r, input bit rd, input bit icr, input bit miss,
                       input logic [31:0] inst, input bit drdy, input bit fl,
                       input logic [31:0] tgt);
        bit e_en, e_dv, pop, hit;
        @(negedge clk);
        rst = r; rdy = rd;
        bus.icache_if_rdy_in       = icr;
        bus.icache_if_miss_in      = miss;
        bus.icache_if_inst_inst_in = inst;
        bus.dec_if_ready_in        = drdy;
        bus.rob_if_flush_in        = fl;
        bus.rob_if_target_in       = tgt;
        #1;
        s_en = bus.if_icache_en_out;     s_addr = bus.if_icache_inst_addr_out;
        s_dv = bus.if_dec_valid_out;     s_inst = bus.if_dec_inst_out;
        s_pc = bus.if_dec_pc_out;

        e_en = !r && rd && !fl && (m_wait || (mq_pc.size() < 16 && icr));
        e_dv = !r && !fl && mq_pc.size() != 0;
        chk("en",   {31'b0, s_en}, {31'b0, e_en});
        chk("addr", s_addr, m_pc);
        chk("dv",   {31'b0, s_dv}, {31'b0, e_dv});
        chk("inst", s_inst, mq_inst.size() != 0 ? mq_inst[0] : 32'h0);
        chk("pc",   s_pc,   mq_pc.size()   != 0 ? mq_pc[0]   : 32'h0);

        if (r) begin
            mq_pc.delete(); mq_inst.delete(); m_pc = 32'h0; m_wait = 0;
        end else if (rd) begin
            if (fl) begin
                mq_pc.delete(); mq_inst.delete(); m_pc = tgt; m_wait = 0;
            end else begin
                hit = e_en && !miss;
                pop = e_dv && drdy;
                if (pop) begin
                    void'(mq_pc.pop_front()); void'(mq_inst.pop_front());
                end
                if (hit) begin
                    mq_pc.push_back(m_pc); mq_inst.push_back(inst);
                    m_pc = model_next(m_pc, inst); m_wait = 0;
                end else if (e_en) begin
                    m_wait = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        cyc(1, 1, 1, 0, NOP, 0, 0, 0);
        cyc(1, 1, 1, 0, NOP, 0, 0, 0);
    endtask

    task automatic hit(input logic [31:0] inst, input bit drdy);
        cyc(0, 1, 1, 0, inst, drdy, 0, 0);
    endtask

    initial begin
        logic [31:0] r32, inst;
        bus.icache_if_rdy_in = 0; bus.icache_if_miss_in = 0;
        bus.icache_if_inst_inst_in = 0; bus.dec_if_ready_in = 0;
        bus.rob_if_flush_in = 0; bus.rob_if_target_in = 0;

        // reset state
        do_reset();
        chk("rst_en",   {31'b0, s_en}, 32'h0);
        chk("rst_dv",   {31'b0, s_dv}, 32'h0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_inst", s_inst, 32'h0);

        // fill to full with decoder stalled
        for (int k = 0; k < 16; k++) begin
            hit(NOP, 0);
            chk("fill_addr", s_addr, 32'(4 * k));
            chk("fill_en", {31'b0, s_en}, 32'h1);
            if (k == 0) chk("fill_dv0", {31'b0, s_dv}, 32'h0);
            if (k == 1) chk("fill_dv1", {31'b0, s_dv}, 32'h1);
        end
        hit(NOP, 0);
        chk("full_en", {31'b0, s_en}, 32'h0);
        chk("full_addr", s_addr, 32'h40);
        hit(NOP, 1);
        chk("pop_en", {31'b0, s_en}, 32'h0);
        chk("pop_pc", s_pc, 32'h0);
        hit(NOP, 0);
        chk("refill_en", {31'b0, s_en}, 32'h1);
        chk("refill_addr", s_addr, 32'h40);
        hit(NOP, 0);
        chk("refull_en", {31'b0, s_en}, 32'h0);
        chk("refull_addr", s_addr, 32'h44);

        // miss at 0x10 for three cycles
        do_reset();
        for (int k = 0; k < 4; k++) hit(NOP, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 1, 32'hdeadbeef, 0, 0, 0);
            chk("miss_en", {31'b0, s_en}, 32'h1);
            chk("miss_addr", s_addr, 32'h10);
        end
        cyc(0, 1, 0, 0, 32'h00100093, 0, 0, 0);
        chk("miss_hit_en", {31'b0, s_en}, 32'h1);
        cyc(0, 1, 0, 0, NOP, 1, 0, 0);
        chk("after_miss_addr", s_addr, 32'h14);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, NOP, 1, 0, 0);
        cyc(0, 1, 0, 0, NOP, 0, 0, 0);
        chk("miss_entry_pc", s_pc, 32'h10);
        chk("miss_entry_inst", s_inst, 32'h00100093);

        // static JAL
        do_reset();
        hit(NOP, 1); hit(NOP, 1); hit(32'h0080006F, 1);
        chk("jal_at", s_addr, 32'h8);
        hit(NOP, 1);
        chk("jal_tgt", s_addr, 32'h10);

        // flush with simultaneous hit and pop
        do_reset();
        for (int k = 0; k < 5; k++) hit(NOP, 0);
        cyc(0, 1, 1, 0, NOP, 1, 1, 32'h200);
        chk("fl_en", {31'b0, s_en}, 32'h0);
        chk("fl_dv", {31'b0, s_dv}, 32'h0);
        cyc(0, 1, 0, 0, NOP, 1, 0, 0);
        chk("fl_addr", s_addr, 32'h200);
        chk("fl_cnt0", {31'b0, s_dv}, 32'h0);
        hit(NOP, 0);
        chk("fl_req", s_addr, 32'h200);

        // rdy_in low mid-WAIT with three entries
        do_reset();
        for (int k = 0; k < 3; k++) hit(NOP, 0);
        cyc(0, 1, 1, 1, NOP, 0, 0, 0);
        chk("w_addr", s_addr, 32'hC);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 1, 1, NOP, 1, 0, 0);
            chk("frz_en", {31'b0, s_en}, 32'h0);
            chk("frz_addr", s_addr, 32'hC);
            chk("frz_pc", s_pc, 32'h0);
        end
        cyc(0, 1, 0, 1, NOP, 0, 0, 0);
        chk("res_en", {31'b0, s_en}, 32'h1);
        chk("res_addr", s_addr, 32'hC);
        chk("res_head", s_pc, 32'h0);
        hit(NOP, 0);
        hit(NOP, 0);
        chk("res_next", s_addr, 32'h10);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            r32 = $urandom;
            inst = (($urandom_range(0, 3)) == 0) ? {r32[31:7], 7'b1101111}
                                                 : {r32[31:7], 7'b0010011};
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 9) != 0,
                $urandom_range(0, 4) != 0,
                $urandom_range(0, 9) < 3,
                inst,
                $urandom_range(0, 9) < (n % 1000 < 500 ? 2 : 7),
                $urandom_range(0, 39) == 0,
                $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
